mips_mc_control: RTL

MIPS_MC_CONTROL -- requirements
Module: mips_mc_control

---
 rtl/mips_ctrl_pkg.sv | 66 ++++++
 rtl/mips_ctrl_outdec.sv | 89 ++++++++
 rtl/mips_mc_control.sv | 134 +++++++++++++
 3 files changed

// File: rtl/mips_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mips_ctrl_pkg
//  Purpose  : Shared definitions for the multi-cycle MIPS control unit.
//             Holds the FSM state codes, opcode values, ALU-op encodings,
//             PC-source encodings and the packed control-word layout.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package mips_ctrl_pkg;

  // FSM state codes (also exported on the debug state port)
  localparam logic [3:0] S_FETCH     = 4'd0;
  localparam logic [3:0] S_DECODE    = 4'd1;
  localparam logic [3:0] S_MEM_ADDR  = 4'd2;
  localparam logic [3:0] S_MEM_READ  = 4'd3;
  localparam logic [3:0] S_MEM_WB    = 4'd4;
  localparam logic [3:0] S_MEM_WRITE = 4'd5;
  localparam logic [3:0] S_R_EXEC    = 4'd6;
  localparam logic [3:0] S_R_WB      = 4'd7;
  localparam logic [3:0] S_BRANCH    = 4'd8;
  localparam logic [3:0] S_JUMP      = 4'd9;
  localparam logic [3:0] S_ADDI_EXEC = 4'd10;
  localparam logic [3:0] S_ADDI_WB   = 4'd11;
  localparam logic [3:0] S_ILLEGAL   = 4'd12;

  // Instruction opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  // ALU operation requests
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  // PC source selects
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Control word carried from the decoder to the top
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       ir_write;
    logic       alu_src_a;
    logic       reg_write;
    logic       reg_dst;
    logic       illegal_op;
    logic [1:0] pc_source;
    logic [1:0] alu_op;
    logic [1:0] alu_src_b;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

endpackage
`default_nettype wire

// File: rtl/mips_ctrl_outdec.sv
`default_nettype none
// ============================================================================
//  Module   : mips_ctrl_outdec
//  Purpose  : Purely combinational Moore output decoder: maps the current FSM
//             state (plus mem_ready for the FETCH handshake) onto the full
//             control word. Anything not set for a state stays 0.
//  Ports    : i_state     [3:0]        current FSM state code
//             i_mem_ready              memory completes this cycle
//             o_ctrl      [CTRL_W-1:0] packed ctrl_t control word
//  Revision : 1.0 - initial release
// ============================================================================
module mips_ctrl_outdec
  import mips_ctrl_pkg::*;
(
  input  logic [3:0]        i_state,
  input  logic              i_mem_ready,
  output logic [CTRL_W-1:0] o_ctrl
);

  ctrl_t w_ctrl;

  always_comb begin
    w_ctrl = '0;
    case (i_state)
      S_FETCH: begin
        w_ctrl.mem_read  = 1'b1;
        // IR load and PC increment commit only on the completing cycle
        w_ctrl.ir_write  = i_mem_ready;
        w_ctrl.pc_write  = i_mem_ready;
        w_ctrl.alu_src_b = 2'b01;
        w_ctrl.alu_op    = ALU_ADD;
        w_ctrl.pc_source = PCSRC_ALU;
      end
      S_DECODE: begin
        w_ctrl.alu_src_b = 2'b11;
        w_ctrl.alu_op    = ALU_ADD;
      end
      S_MEM_ADDR, S_ADDI_EXEC: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = 2'b10;
        w_ctrl.alu_op    = ALU_ADD;
      end
      S_MEM_READ: begin
        w_ctrl.mem_read = 1'b1;
        w_ctrl.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.mem_to_reg = 1'b1;
      end
      S_MEM_WRITE: begin
        w_ctrl.mem_write = 1'b1;
        w_ctrl.i_or_d    = 1'b1;
      end
      S_R_EXEC: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = 2'b00;
        w_ctrl.alu_op    = ALU_FUNCT;
      end
      S_R_WB: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        // The zero flag gates the PC write outside this block
        w_ctrl.alu_src_a     = 1'b1;
        w_ctrl.alu_src_b     = 2'b00;
        w_ctrl.alu_op        = ALU_SUB;
        w_ctrl.pc_write_cond = 1'b1;
        w_ctrl.pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        w_ctrl.pc_write  = 1'b1;
        w_ctrl.pc_source = PCSRC_JUMP;
      end
      S_ADDI_WB: begin
        w_ctrl.reg_write = 1'b1;
      end
      S_ILLEGAL: begin
        w_ctrl.illegal_op = 1'b1;
      end
      default: w_ctrl = '0;
    endcase
  end

  assign o_ctrl = w_ctrl;

endmodule
`default_nettype wire

// File: rtl/mips_mc_control.sv
`default_nettype none
// ============================================================================
//  Module   : mips_mc_control
//  Purpose  : Multi-cycle MIPS control unit (Moore FSM). Holds the state
//             register and next-state logic; output decoding lives in
//             mips_ctrl_outdec. Optional performance counters are built in
//             when the macro MC_PERF_COUNTERS_EN is defined.
//  Ports    : clock, reset (sync, active-low), opcode[5:0], zero, mem_ready
//             1-bit controls: pc_write, pc_write_cond, i_or_d, mem_read,
//               mem_write, mem_to_reg, ir_write, alu_src_a, reg_write,
//               reg_dst, illegal_op
//             2-bit controls: pc_source, alu_op, alu_src_b
//             state[3:0] debug state code
//             cycle_count[31:0], instr_count[31:0] (MC_PERF_COUNTERS_EN only)
//  Revision : 1.0 - initial release
// ============================================================================
module mips_mc_control
  import mips_ctrl_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        pc_write_cond,
  output logic        i_or_d,
  output logic        mem_read,
  output logic        mem_write,
  output logic        mem_to_reg,
  output logic        ir_write,
  output logic        alu_src_a,
  output logic        reg_write,
  output logic        reg_dst,
  output logic        illegal_op,
  output logic [1:0]  pc_source,
  output logic [1:0]  alu_op,
  output logic [1:0]  alu_src_b,
  output logic [3:0]  state
`ifdef MC_PERF_COUNTERS_EN
  ,
  output logic [31:0] cycle_count,
  output logic [31:0] instr_count
`endif
);

  logic [3:0]        r_state;
  logic [3:0]        w_next;
  logic [CTRL_W-1:0] w_dec_bits;
  ctrl_t             w_ctrl;
  // The branch decision on zero is taken by the datapath, not here
  logic              w_unused_zero;

  assign w_unused_zero = zero;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:     if (mem_ready) w_next = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:     w_next = S_R_EXEC;
          OP_LW, OP_SW: w_next = S_MEM_ADDR;
          OP_BEQ:       w_next = S_BRANCH;
          OP_J:         w_next = S_JUMP;
          OP_ADDI:      w_next = S_ADDI_EXEC;
          default:      w_next = S_ILLEGAL;
        endcase
      end
      S_MEM_ADDR:  w_next = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  if (mem_ready) w_next = S_MEM_WB;
      S_MEM_WRITE: if (mem_ready) w_next = S_FETCH;
      S_R_EXEC:    w_next = S_R_WB;
      S_ADDI_EXEC: w_next = S_ADDI_WB;
      S_MEM_WB, S_R_WB, S_ADDI_WB, S_BRANCH, S_JUMP:
                   w_next = S_FETCH;
      S_ILLEGAL:   w_next = S_ILLEGAL;
      default:     w_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) r_state <= S_FETCH;
    else        r_state <= w_next;
  end

  mips_ctrl_outdec u_outdec (
    .i_state     (r_state),
    .i_mem_ready (mem_ready),
    .o_ctrl      (w_dec_bits)
  );

  // Controls are forced quiet combinationally while reset is held, so a
  // reset landing mid-access drops enables in the same cycle.
  assign w_ctrl = reset ? ctrl_t'(w_dec_bits) : '0;

  assign pc_write      = w_ctrl.pc_write;
  assign pc_write_cond = w_ctrl.pc_write_cond;
  assign i_or_d        = w_ctrl.i_or_d;
  assign mem_read      = w_ctrl.mem_read;
  assign mem_write     = w_ctrl.mem_write;
  assign mem_to_reg    = w_ctrl.mem_to_reg;
  assign ir_write      = w_ctrl.ir_write;
  assign alu_src_a     = w_ctrl.alu_src_a;
  assign reg_write     = w_ctrl.reg_write;
  assign reg_dst       = w_ctrl.reg_dst;
  assign illegal_op    = w_ctrl.illegal_op;
  assign pc_source     = w_ctrl.pc_source;
  assign alu_op        = w_ctrl.alu_op;
  assign alu_src_b     = w_ctrl.alu_src_b;
  assign state         = r_state;

`ifdef MC_PERF_COUNTERS_EN
  logic [31:0] r_cycle_count;
  logic [31:0] r_instr_count;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_cycle_count <= 32'd0;
      r_instr_count <= 32'd0;
    end else begin
      r_cycle_count <= r_cycle_count + 32'd1;
      // One instruction counted per FETCH->DECODE hand-off
      if (r_state == S_FETCH && mem_ready)
        r_instr_count <= r_instr_count + 32'd1;
    end
  end

  assign cycle_count = r_cycle_count;
  assign instr_count = r_instr_count;
`endif

endmodule
`default_nettype wire
